inst_rom_arbiter: RTL and testbench
===================================

INST_ROM_ARBITER -- requirements
Module: inst_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ROM_DEPTH, default 20, meaning the number of valid instruction words; addr >= ROM_DEPTH is out of range.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the word-address width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum consecutive grants to one port while the other port waits.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low (clk, resetn).
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- req0_valid  in  1  port 0 (fetch) request
- req0_addr  in  ADDR_W  port 0 word address
- req0_ready  out  1  port 0 request accepted
- rsp0_valid  out  1  port 0 response valid
- rsp0_inst  out  32  port 0 instruction
- rsp0_oob  out  1  port 0 address out of range
- rsp0_ready  in  1  port 0 response consumed
- req1_*/rsp1_*  same widths  port 1 (debug/display reader)
- rom_addr  out  ADDR_W  address to the asynchronous ROM
- rom_inst  in  32  ROM data, valid in the same cycle

Function
REQ-006 A port SHALL be eligible when req_valid=1 and its response slot is empty, or full with rsp_ready=1 in the same cycle.
REQ-007 At most one port SHALL be granted per cycle; req_ready of the granted port SHALL be 1 combinationally, and the other port's req_ready SHALL be 0.
REQ-008 If exactly one port is eligible, it SHALL be granted.
REQ-009 If both ports are eligible and the last-granted port has burst_cnt < BURST_MAX, the last-granted port SHALL be granted again.
REQ-010 If both ports are eligible and the last-granted port has burst_cnt = BURST_MAX, the other port SHALL be granted.
REQ-011 rom_addr SHALL equal the granted port's req_addr, and SHALL be 0 when no port is granted.
REQ-012 On a grant, the granted port's slot SHALL load rom_inst, and rsp_oob = (addr >= ROM_DEPTH), at the next clock edge, giving rsp_valid=1 one cycle after the handshake.
REQ-013 An out-of-range response SHALL carry rsp_inst = 0 regardless of rom_inst.
REQ-014 rsp_valid, rsp_inst and rsp_oob SHALL hold stable until rsp_valid & rsp_ready.
REQ-015 A pop and a new grant on the same port in the same cycle SHALL be allowed, sustaining 1 response per cycle per port.
REQ-016 burst_cnt SHALL set to 1 when the granted port differs from last_grant, SHALL increment (saturating at BURST_MAX) when the same port is granted again, and SHALL clear to 0 on a cycle with no grant.
REQ-017 last_grant SHALL update only on a grant.
REQ-018 Response slot state machine per port: EMPTY->FULL on grant; FULL->EMPTY on pop without grant; FULL->FULL on pop with grant (new data) or on no pop.

Reset
REQ-019 On resetn=0, all rsp_valid, rsp_inst and rsp_oob SHALL be 0, burst_cnt SHALL be 0, and last_grant SHALL be 1, so port 0 wins the first tie.
REQ-020 Reset asserted mid-transaction SHALL discard pending responses, with no response emitted after deassertion.
REQ-021 req_ready outputs SHALL be 0 while resetn=0.

Structure
REQ-022 A shared package SHALL hold ROM_DEPTH, ADDR_W and BURST_MAX defaults, the port-index constants, and the slot state encoding (EMPTY, FULL).
REQ-023 The one-entry response buffer SHALL be a sub-module rom_rsp_slot, instantiated once per port; the arbitration and burst logic SHALL stay in the top module.

Verification
REQ-024 Scenario: port 0 alone, addr 2, rsp0_ready=1 -> req0_ready=1 same cycle, then rsp0_valid=1, rsp0_inst=0x00221821, rsp0_oob=0 next cycle.
REQ-025 Scenario: both request every cycle after reset, both rsp_ready=1 -> grant sequence 0,0,0,0,1,1,1,1,0... (BURST_MAX=4).
REQ-026 Scenario: port 1 addr 25 -> rsp1_valid=1, rsp1_inst=0, rsp1_oob=1.
REQ-027 Scenario: port 0 rsp0_ready=0 holding addr 5 response, port 0 requests again -> req0_ready=0, rsp0_inst stays 0x00853024; port 1 granted meanwhile.
REQ-028 Scenario: port 0 streams addrs 0,1,2 with rsp0_ready=1 -> back-to-back responses 0x2401000A, 0x24020014, 0x00221821 on consecutive cycles.
REQ-029 Scenario: resetn pulsed low while rsp1_valid=1 -> rsp1_valid=0 immediately (async); first tie after release grants port 0.

Source files
------------

// File: rtl/inst_rom_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// inst_rom_arbiter_pkg
// Shared definitions for the two-port instruction ROM arbiter:
//   - default values for ROM_DEPTH, ADDR_W and BURST_MAX
//   - port-index constants (PORT0 = fetch, PORT1 = debug/display reader)
//   - encoding of the one-entry response slot state machine
// ----------------------------------------------------------------------------
package inst_rom_arbiter_pkg;

    localparam int ROM_DEPTH_DEFAULT = 20;
    localparam int ADDR_W_DEFAULT    = 5;
    localparam int BURST_MAX_DEFAULT = 4;

    localparam int NUM_PORTS = 2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : inst_rom_arbiter_pkg

// File: rtl/inst_rom_arbiter_rsp_slot.sv
// ----------------------------------------------------------------------------
// rom_rsp_slot
// One-entry response buffer for one arbiter port. A grant loads the ROM word
// and its out-of-range flag; the entry is presented until consumed. A pop and
// a new load in the same cycle keep the slot full with the new data, so one
// response per cycle can be sustained.
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   load            port granted this cycle: capture load_inst / load_oob
//   load_inst       ROM data for the granted address
//   load_oob        granted address is out of range (data forced to 0)
//   rsp_ready       consumer takes the current response this cycle
//   rsp_valid       slot holds a response
//   rsp_inst        held instruction word
//   rsp_oob         held out-of-range flag
//   can_accept      slot can take a new load this cycle (empty, or popping)
// ----------------------------------------------------------------------------
module rom_rsp_slot
    import inst_rom_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic        load_oob,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_inst,
    output logic        rsp_oob,
    output logic        can_accept
);

    slot_state_t state_reg;
    slot_state_t state_next;
    logic [31:0] inst_reg;
    logic        oob_reg;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= SLOT_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Payload: only written on load, so it stays stable while waiting for the
    // consumer (the arbiter never loads a full slot that is not being popped).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_reg <= '0;
            oob_reg  <= 1'b0;
        end else if (load) begin
            inst_reg <= load_oob ? 32'h0000_0000 : load_inst;
            oob_reg  <= load_oob;
        end
    end

    // Outputs
    always_comb begin
        rsp_valid  = (state_reg == SLOT_FULL);
        rsp_inst   = inst_reg;
        rsp_oob    = oob_reg;
        can_accept = (state_reg == SLOT_EMPTY) || rsp_ready;
    end

endmodule : rom_rsp_slot

// File: rtl/inst_rom_arbiter.sv
// ----------------------------------------------------------------------------
// inst_rom_arbiter
// Two-port arbiter in front of an asynchronous instruction ROM. Each cycle at
// most one eligible port is granted; its address drives rom_addr and the
// returned word is captured in that port's response slot at the next edge.
// Ties are resolved with a bounded burst: the last-granted port keeps the ROM
// for up to BURST_MAX consecutive grants while the other port waits.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   req0_valid/addr/ready        port 0 (fetch) request handshake
//   rsp0_valid/inst/oob/ready    port 0 response handshake
//   req1_* / rsp1_*              port 1 (debug/display reader), same widths
//   rom_addr                     address to the ROM (0 when idle)
//   rom_inst                     ROM data, valid in the same cycle
// ----------------------------------------------------------------------------
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [31:0]       rsp0_inst,
    output logic              rsp0_oob,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [31:0]       rsp1_inst,
    output logic              rsp1_oob,
    input  logic              rsp1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst
);

    localparam int                 BURST_W     = $clog2(BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_ONE   = BURST_W'(1);

    // Per-port views of the flat port list
    logic [NUM_PORTS-1:0] req_valid;
    logic [ADDR_W-1:0]    req_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0] rsp_ready;
    logic [NUM_PORTS-1:0] rsp_valid;
    logic [31:0]          rsp_inst [NUM_PORTS];
    logic [NUM_PORTS-1:0] rsp_oob;
    logic [NUM_PORTS-1:0] can_accept;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant_onehot;

    logic                 grant_any;
    logic                 grant_port;
    logic                 grant_oob;
    logic                 burst_continue;

    logic                 last_grant_reg;
    logic                 last_grant_next;
    logic [BURST_W-1:0]   burst_cnt_reg;
    logic [BURST_W-1:0]   burst_cnt_next;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign rsp_ready   = {rsp1_ready, rsp0_ready};

    assign rsp0_valid = rsp_valid[0];
    assign rsp0_inst  = rsp_inst[0];
    assign rsp0_oob   = rsp_oob[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp1_inst  = rsp_inst[1];
    assign rsp1_oob   = rsp_oob[1];

    assign req0_ready = grant_onehot[0];
    assign req1_ready = grant_onehot[1];

    // A port may be granted only if its slot can take the new word this cycle
    assign eligible = req_valid & can_accept;

    // Arbitration. A burst is "in progress" when burst_cnt is between 1 and
    // BURST_MAX-1; on a tie such a burst is extended. Otherwise (burst used up,
    // or no burst because the previous cycle was idle / just out of reset) the
    // tie goes to the port that was not granted last. With last_grant = 1 out
    // of reset, port 0 wins the first tie.
    always_comb begin
        grant_any      = 1'b0;
        grant_port     = PORT0;
        burst_continue = (burst_cnt_reg != '0) && (burst_cnt_reg < BURST_MAX_C);
        case (eligible)
            2'b01: begin
                grant_any  = 1'b1;
                grant_port = PORT0;
            end
            2'b10: begin
                grant_any  = 1'b1;
                grant_port = PORT1;
            end
            2'b11: begin
                grant_any  = 1'b1;
                grant_port = burst_continue ? last_grant_reg : ~last_grant_reg;
            end
            default: begin
                grant_any  = 1'b0;
                grant_port = PORT0;
            end
        endcase
        // Nothing is handed out while reset is asserted
        if (!resetn) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_any) begin
            grant_onehot[grant_port] = 1'b1;
        end
    end

    assign rom_addr  = grant_any ? req_addr[grant_port] : '0;
    assign grant_oob = (32'(rom_addr) >= ROM_DEPTH);

    // Burst counter / last-grant bookkeeping
    always_comb begin
        last_grant_next = last_grant_reg;
        burst_cnt_next  = '0;
        if (grant_any) begin
            last_grant_next = grant_port;
            if (grant_port != last_grant_reg) begin
                burst_cnt_next = BURST_ONE;
            end else if (burst_cnt_reg >= BURST_MAX_C) begin
                burst_cnt_next = BURST_MAX_C;
            end else begin
                burst_cnt_next = burst_cnt_reg + BURST_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= PORT1;
            burst_cnt_reg  <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    // One response slot per port
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
            rom_rsp_slot u_slot (
                .clk        (clk),
                .resetn     (resetn),
                .load       (grant_onehot[gi]),
                .load_inst  (rom_inst),
                .load_oob   (grant_oob),
                .rsp_ready  (rsp_ready[gi]),
                .rsp_valid  (rsp_valid[gi]),
                .rsp_inst   (rsp_inst[gi]),
                .rsp_oob    (rsp_oob[gi]),
                .can_accept (can_accept[gi])
            );
        end
    endgenerate

endmodule : inst_rom_arbiter

// File: tb/tb_inst_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_inst_rom_arbiter
// Scoreboard bench: each grant predicted by the reference model pushes the
// expected {oob, inst} onto that port's queue; an independent monitor pops and
// compares whenever a response is consumed.
// ----------------------------------------------------------------------------
module tb_inst_rom_arbiter;

    localparam int ROM_DEPTH = 20;
    localparam int ADDR_W    = 5;
    localparam int BMAX      = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [31:0]       rsp0_inst, rsp1_inst;
    logic              rsp0_oob, rsp1_oob;
    logic              rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int m_occ[2];
    int m_last;
    int m_burst;

    always #5 clk = ~clk;

    inst_rom_arbiter #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W),
        .BURST_MAX (BMAX)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_inst  (rsp0_inst),
        .rsp0_oob   (rsp0_oob),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_inst  (rsp1_inst),
        .rsp1_oob   (rsp1_oob),
        .rsp1_ready (rsp1_ready),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst)
    );

    // ROM contents: a few known program words, a recognisable filler
    // elsewhere (also returned beyond ROM_DEPTH, so out-of-range zeroing is
    // visible).
    function automatic logic [31:0] rom_word(input logic [4:0] a);
        case (a)
            5'd0:    return 32'h2401000A;
            5'd1:    return 32'h24020014;
            5'd2:    return 32'h00221821;
            5'd5:    return 32'h00853024;
            default: return 32'hC0DE0000 | {27'd0, a};
        endcase
    endfunction

    always_comb rom_inst = rom_word(rom_addr);

    function automatic logic [32:0] expected_rsp(input logic [4:0] a);
        if (int'(a) < ROM_DEPTH) return {1'b0, rom_word(a)};
        return {1'b1, 32'h0};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_occ[0] = 0;
        m_occ[1] = 0;
        m_last   = 1;
        m_burst  = 0;
    endtask

    // One clock of stimulus plus model prediction. g returns the granted port
    // (-1 when idle).
    task automatic cycle(input bit v0, input logic [4:0] a0, input bit r0,
                         input bit v1, input logic [4:0] a1, input bit r1,
                         output int g);
        bit e0, e1;
        logic [4:0] ga;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_addr = a0; rsp0_ready = r0;
        req1_valid = v1; req1_addr = a1; rsp1_ready = r1;
        @(negedge clk);
        e0 = v0 && (m_occ[0] == 0 || r0);
        e1 = v1 && (m_occ[1] == 0 || r1);
        if (e0 && e1) begin
            // burst of fewer than BMAX grants in progress keeps the ROM
            if (m_burst > 0 && m_burst < BMAX) g = m_last;
            else g = 1 - m_last;
        end else if (e0) g = 0;
        else if (e1) g = 1;
        else g = -1;
        ga = (g == 0) ? a0 : (g == 1) ? a1 : 5'd0;
        check("req0_ready", {32'd0, req0_ready}, {32'd0, g == 0});
        check("req1_ready", {32'd0, req1_ready}, {32'd0, g == 1});
        check("rom_addr", {28'd0, rom_addr}, {28'd0, ga});
        check("rsp0_valid", {32'd0, rsp0_valid}, 33'(m_occ[0]));
        check("rsp1_valid", {32'd0, rsp1_valid}, 33'(m_occ[1]));
        if (g == 0) q0.push_back(expected_rsp(a0));
        if (g == 1) q1.push_back(expected_rsp(a1));
        // slot occupancy for next cycle
        if (g == 0) m_occ[0] = 1; else if (r0) m_occ[0] = 0;
        if (g == 1) m_occ[1] = 1; else if (r1) m_occ[1] = 0;
        // burst bookkeeping
        if (g < 0) m_burst = 0;
        else if (g != m_last) m_burst = 1;
        else if (m_burst < BMAX) m_burst = m_burst + 1;
        if (g >= 0) m_last = g;
    endtask

    // Monitor: compares every consumed response against the scoreboard
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (resetn && rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", {rsp0_oob, rsp0_inst}, 33'h1_FFFF_FFFF);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_data", {rsp0_oob, rsp0_inst}, e);
                    $display("rsp0 inst=0x%08h oob=%0b", rsp0_inst, rsp0_oob);
                end
            end
            if (resetn && rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", {rsp1_oob, rsp1_inst}, 33'h1_FFFF_FFFF);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_data", {rsp1_oob, rsp1_inst}, e);
                    $display("rsp1 inst=0x%08h oob=%0b", rsp1_inst, rsp1_oob);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int exp_seq[9];
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        model_reset();

        // Reset state, with requests pending
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_req0_ready", {32'd0, req0_ready}, 33'd0);
        check("reset_req1_ready", {32'd0, req1_ready}, 33'd0);
        check("reset_rsp0", {rsp0_valid, rsp0_oob, rsp0_inst}, 34'd0);
        check("reset_rsp1", {rsp1_valid, rsp1_oob, rsp1_inst}, 34'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Both ports request every cycle: burst pattern
        for (int i = 0; i < 9; i++) begin
            cycle(1, 5'($urandom_range(0, 31)), 1, 1, 5'($urandom_range(0, 31)), 1, g);
            check("grant_seq", 33'(g), 33'(exp_seq[i]));
        end
        cycle(0, 0, 1, 0, 0, 1, g);
        cycle(0, 0, 1, 0, 0, 1, g);

        // Port 0 alone, addr 2
        cycle(1, 5'd2, 1, 0, 0, 1, g);
        check("p0_alone_grant", 33'(g), 33'd0);
        cycle(0, 0, 1, 0, 0, 1, g);
        check("p0_alone_rsp", {rsp0_valid, rsp0_oob, rsp0_inst}, {1'b1, 1'b0, 32'h00221821});

        // Port 1 out of range
        cycle(0, 0, 1, 1, 5'd25, 1, g);
        cycle(0, 0, 1, 0, 0, 1, g);
        check("p1_oob_rsp", {rsp1_valid, rsp1_oob, rsp1_inst}, {1'b1, 1'b1, 32'h0});

        // Port 0 streams 0,1,2
        cycle(1, 5'd0, 1, 0, 0, 1, g);
        cycle(1, 5'd1, 1, 0, 0, 1, g);
        check("stream_rsp0", {rsp0_valid, rsp0_inst}, {1'b1, 32'h2401000A});
        cycle(1, 5'd2, 1, 0, 0, 1, g);
        check("stream_rsp1", {rsp0_valid, rsp0_inst}, {1'b1, 32'h24020014});
        cycle(0, 0, 1, 0, 0, 1, g);
        check("stream_rsp2", {rsp0_valid, rsp0_inst}, {1'b1, 32'h00221821});

        // Port 0 holds addr 5 response (not ready) and requests again
        cycle(1, 5'd5, 0, 0, 0, 1, g);
        cycle(1, 5'd7, 0, 1, 5'd3, 1, g);
        check("stall_grant", 33'(g), 33'd1);
        check("stall_hold", {rsp0_valid, rsp0_inst}, {1'b1, 32'h00853024});
        cycle(1, 5'd7, 0, 0, 0, 1, g);
        check("stall_hold2", {rsp0_valid, rsp0_inst}, {1'b1, 32'h00853024});
        cycle(0, 0, 1, 0, 0, 1, g);
        cycle(0, 0, 1, 0, 0, 1, g);

        // Reset pulsed while port 1 holds a response
        cycle(0, 0, 1, 1, 5'd4, 0, g);
        @(posedge clk);
        #3;
        check("pre_reset_rsp1_valid", {32'd0, rsp1_valid}, 33'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        resetn = 1'b0;
        #1;
        check("async_rsp1_valid", {32'd0, rsp1_valid}, 33'd0);
        check("async_req0_ready", {32'd0, req0_ready}, 33'd0);
        check("async_req1_ready", {32'd0, req1_ready}, 33'd0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle(1, 5'd0, 1, 1, 5'd1, 1, g);
        check("post_reset_tie", 33'(g), 33'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, g);
        end

        // Drain
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 1, g);
        #3;
        check("drain_q0", 33'(q0.size()), 33'd0);
        check("drain_q1", 33'(q1.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_rom_arbiter
